conway_mode_sequencer: RTL and testbench

- Command-driven FSM directly upstream of the system memory; generates its mutually exclusive LOAD_MODE / RUN_MODE / OUTPUT_MODE controls and the SERIAL_IN bit.
- Guarantees the memory's rotate-on-readout invariant: every dump is exactly DATA_SIZE shifts, and every load is exactly DATA_SIZE shifts.
- Also counts generations for run commands.
- Provides valid/ready handshakes toward the external serial host.

---
 rtl/conway_mode_sequencer_if.sv | 31 +++
 rtl/conway_mode_sequencer.sv | 158 +++++++++++++++
 tb/tb_conway_mode_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conway_mode_sequencer_if.sv
// Host-side handshake bundle for conway_mode_sequencer.
// master = serial host, slave = sequencer.
interface conway_mode_sequencer_if #(
  parameter int GEN_WIDTH = 16
);
  logic                 CMD_VALID;
  logic                 CMD_READY;
  logic [1:0]           CMD_OP;
  logic [GEN_WIDTH-1:0] CMD_ARG;
  logic                 SER_IN_VALID;
  logic                 SER_IN_DATA;
  logic                 SER_IN_READY;
  logic                 SER_OUT_READY;
  logic                 SER_OUT_VALID;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ARG,
    output SER_IN_VALID, SER_IN_DATA,
    output SER_OUT_READY,
    input  CMD_READY, SER_IN_READY,
    input  SER_OUT_VALID
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ARG,
    input  SER_IN_VALID, SER_IN_DATA,
    input  SER_OUT_READY,
    output CMD_READY, SER_IN_READY,
    output SER_OUT_VALID
  );
endinterface

// File: rtl/conway_mode_sequencer.sv
// Command FSM driving LOAD/RUN/OUTPUT modes of the Conway memory.
// Ports: CLK, RESET (async, active-high); host = handshake bundle
// (slave): CMD_*, SER_IN_*, SER_OUT_*; memory side: LOAD_MODE,
// RUN_MODE, OUTPUT_MODE, SERIAL_IN; status: BUSY, DONE, ERROR.
// Optional: define CONWAY_LOAD_TIMEOUT_EN to abort stalled loads.
module conway_mode_sequencer #(
  parameter int DATA_SIZE      = 64,
  parameter int GEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RESET,
  conway_mode_sequencer_if.slave  host,
  output logic                    LOAD_MODE,
  output logic                    RUN_MODE,
  output logic                    OUTPUT_MODE,
  output logic                    SERIAL_IN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR
);
  localparam int BW = $clog2(DATA_SIZE + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
  logic [GEN_WIDTH-1:0] r_gen_cnt, w_gen_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_error, w_err_nxt;
  logic                 r_sov;

`ifdef CONWAY_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt, w_to_nxt;
`endif

  // Mode decode: states are exclusive, so modes are too.
  assign LOAD_MODE   = (r_state == S_LOAD) & host.SER_IN_VALID;
  assign RUN_MODE    = (r_state == S_RUN) & (|r_gen_cnt);
  assign OUTPUT_MODE = (r_state == S_DUMP) & host.SER_OUT_READY;
  assign SERIAL_IN   = host.SER_IN_DATA;
  assign BUSY        = (r_state != S_IDLE);
  assign DONE        = r_done;
  assign ERROR       = r_error;

  assign host.CMD_READY     = (r_state == S_IDLE);
  assign host.SER_IN_READY  = (r_state == S_LOAD);
  assign host.SER_OUT_VALID = r_sov;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_gen_nxt   = r_gen_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
`ifdef CONWAY_LOAD_TIMEOUT_EN
    w_to_nxt    = r_to_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (host.CMD_VALID) begin
          w_bit_nxt = '0;
`ifdef CONWAY_LOAD_TIMEOUT_EN
          w_to_nxt  = '0;
`endif
          unique case (host.CMD_OP)
            2'b00: w_state_nxt = S_LOAD;
            2'b01: begin
              w_state_nxt = S_RUN;
              w_gen_nxt   = host.CMD_ARG;
            end
            2'b10: w_state_nxt = S_DUMP;
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (host.SER_IN_VALID) begin
          w_bit_nxt = r_bit_cnt + BW'(1);
`ifdef CONWAY_LOAD_TIMEOUT_EN
          w_to_nxt  = '0;
`endif
          if (r_bit_cnt == LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
`ifdef CONWAY_LOAD_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          // Abandon a stalled load; memory is partial.
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
          w_to_nxt    = '0;
        end else begin
          w_to_nxt = r_to_cnt + TW'(1);
        end
`endif
      end
      S_RUN: begin
        // Zero-generation run still completes with DONE.
        if (r_gen_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_gen_nxt = r_gen_cnt - GEN_WIDTH'(1);
          if (r_gen_cnt == GEN_WIDTH'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_DUMP: begin
        if (host.SER_OUT_READY) begin
          w_bit_nxt = r_bit_cnt + BW'(1);
          // DONE lands with the last registered SERIAL_OUT bit.
          if (r_bit_cnt == LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_gen_cnt <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_sov     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_gen_cnt <= w_gen_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_err_nxt;
      r_sov     <= OUTPUT_MODE;
    end
  end

`ifdef CONWAY_LOAD_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_to_cnt <= '0;
    else       r_to_cnt <= w_to_nxt;
  end
`endif
endmodule

// File: tb/tb_conway_mode_sequencer.sv
// Directed bench for conway_mode_sequencer (DATA_SIZE=8)
// with a behavioural rotate-on-readout memory model.
module tb_conway_mode_sequencer;
  localparam int DS = 8;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RESET;
  logic LOAD_MODE, RUN_MODE, OUTPUT_MODE;
  logic SERIAL_IN, BUSY, DONE, ERROR;

  conway_mode_sequencer_if #(.GEN_WIDTH(16)) bus();

  conway_mode_sequencer #(
    .DATA_SIZE(DS),
    .GEN_WIDTH(16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .host(bus),
    .LOAD_MODE(LOAD_MODE),
    .RUN_MODE(RUN_MODE),
    .OUTPUT_MODE(OUTPUT_MODE),
    .SERIAL_IN(SERIAL_IN),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem = 8'h00;
  logic       sout = 1'b0;
  always @(posedge CLK) begin
    if (LOAD_MODE) mem <= {mem[6:0], SERIAL_IN};
    if (OUTPUT_MODE) begin
      mem  <= {mem[6:0], mem[7]};
      sout <= mem[7];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [15:0] arg);
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = op;
    bus.CMD_ARG   = arg;
    tick();
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v,
                         output int nmode,
                         output int ndone);
    nmode = 0;
    ndone = 0;
    for (int i = 0; i < 18; i++) begin
      bus.SER_IN_VALID = (i < 16) && (i % 2 == 0);
      if (i < 16) bus.SER_IN_DATA = v[7 - i/2];
      #1;
      if (LOAD_MODE) nmode++;
      tick();
      if (DONE) ndone++;
    end
    bus.SER_IN_VALID = 1'b0;
  endtask

  task automatic do_dump(input logic [15:0] stall,
                         output logic [7:0] bits,
                         output int nmode,
                         output int nvalid,
                         output int ndone,
                         output int nalign,
                         output int nbad);
    bits = '0;
    nmode = 0; nvalid = 0; ndone = 0;
    nalign = 0; nbad = 0;
    issue(2'b10, 16'd0);
    for (int i = 0; i < 16; i++) begin
      bus.SER_OUT_READY = !stall[i];
      #1;
      if (OUTPUT_MODE) nmode++;
      if (stall[i] && OUTPUT_MODE) nbad++;
      tick();
      if (bus.SER_OUT_VALID) begin
        bits = {bits[6:0], sout};
        nvalid++;
      end
      if (DONE) begin
        ndone++;
        if (bus.SER_OUT_VALID && nvalid == 8) nalign++;
      end
    end
    bus.SER_OUT_READY = 1'b0;
  endtask

  task automatic do_run(input logic [15:0] arg,
                        output int n,
                        output int span,
                        output int nd);
    int first, last;
    first = -1; last = -1; n = 0; nd = 0;
    issue(2'b01, arg);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (RUN_MODE) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
      if (DONE) nd++;
    end
    span = (first < 0) ? 0 : last - first + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nm, nd, nv, na, nb, sp;
    logic [7:0] b1, b2;

    RESET             = 1'b1;
    bus.CMD_VALID     = 1'b0;
    bus.CMD_OP        = 2'b00;
    bus.CMD_ARG       = '0;
    bus.SER_IN_VALID  = 1'b0;
    bus.SER_IN_DATA   = 1'b0;
    bus.SER_OUT_READY = 1'b0;
    #1;
    check("rst_cmd_ready", bus.CMD_READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_modes",
          {LOAD_MODE, RUN_MODE, OUTPUT_MODE}, 0);
    check("rst_flags",
          {DONE, ERROR, bus.SER_OUT_VALID}, 0);
    tick();
    RESET = 1'b0;
    tick();

    issue(2'b00, 16'd0);
    check("load_busy", BUSY, 1);
    check("load_in_ready", bus.SER_IN_READY, 1);
    do_load(8'hA5, nm, nd);
    check("load_mode_cycles", nm, 8);
    check("load_done_pulses", nd, 1);
    check("load_mem", mem, 8'hA5);
    check("load_cmd_ready", bus.CMD_READY, 1);

    do_dump(16'h0000, b1, nm, nv, nd, na, nb);
    check("dump1_mode_cycles", nm, 8);
    check("dump1_valid_bits", nv, 8);
    check("dump1_bits", b1, 8'hA5);
    check("dump1_done", nd, 1);
    check("dump1_done_align", na, 1);
    check("dump1_mem_kept", mem, 8'hA5);

    do_dump(16'h0000, b2, nm, nv, nd, na, nb);
    check("dump2_bits", b2, 8'hA5);

    do_dump(16'h001C, b2, nm, nv, nd, na, nb);
    check("stall_mode_cycles", nm, 8);
    check("stall_no_shift", nb, 0);
    check("stall_valid_bits", nv, 8);
    check("stall_bits", b2, 8'hA5);
    check("stall_done_align", na, 1);
    check("stall_mem_kept", mem, 8'hA5);

    do_run(16'd3, nm, sp, nd);
    check("run3_cycles", nm, 3);
    check("run3_consecutive", sp, 3);
    check("run3_done", nd, 1);
    do_run(16'd0, nm, sp, nd);
    check("run0_cycles", nm, 0);
    check("run0_done", nd, 1);

    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = 2'b11;
    tick();
    bus.CMD_VALID = 1'b0;
    check("rsv_error", ERROR, 1);
    check("rsv_busy", BUSY, 0);
    check("rsv_cmd_ready", bus.CMD_READY, 1);
    check("rsv_modes",
          {LOAD_MODE, RUN_MODE, OUTPUT_MODE}, 0);
    tick();
    check("rsv_error_once", ERROR, 0);

    issue(2'b00, 16'd0);
    bus.CMD_VALID     = 1'b1;
    bus.CMD_OP        = 2'b10;
    bus.SER_OUT_READY = 1'b1;
    #1;
    check("busy_cmd_ready", bus.CMD_READY, 0);
    check("busy_no_dump", OUTPUT_MODE, 0);
    tick();
    bus.CMD_VALID = 1'b0;
    check("busy_still_load", bus.SER_IN_READY, 1);
    bus.SER_IN_VALID = 1'b1;
    bus.SER_IN_DATA  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    RESET = 1'b1;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_modes",
          {LOAD_MODE, RUN_MODE, OUTPUT_MODE}, 0);
    check("abort_in_ready", bus.SER_IN_READY, 0);
    check("abort_cmd_ready", bus.CMD_READY, 1);
    check("abort_flags",
          {DONE, ERROR, bus.SER_OUT_VALID}, 0);
    bus.SER_IN_VALID  = 1'b0;
    bus.SER_OUT_READY = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    check("abort_no_done", DONE, 0);

`ifdef CONWAY_LOAD_TIMEOUT_EN
    issue(2'b00, 16'd0);
    bus.SER_IN_VALID = 1'b1;
    tick();
    tick();
    bus.SER_IN_VALID = 1'b0;
    nm = 0;
    while (!ERROR && nm < 40) begin
      tick();
      nm++;
    end
    check("to_stall_cycles", nm, 16);
    check("to_no_done", DONE, 0);
    check("to_idle", bus.CMD_READY, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
